// File: rtl/vend_input_conditioner_if.sv
// Signal bundle between the vending input conditioner and its consumers.
// The master side drives the raw inputs; the slave (the conditioner) drives the conditioned outputs.
interface vend_input_conditioner_if #(
  parameter int NUM_BTN = 4
);
  logic               slow_CLK;
  logic [NUM_BTN-1:0] btn_in;
  logic               tick;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  modport master (
    output slow_CLK, btn_in,
    input  tick, btn_level, btn_press, btn_release
  );

  modport slave (
    input  slow_CLK, btn_in,
    output tick, btn_level, btn_press, btn_release
  );
endinterface

// File: rtl/vend_input_conditioner.sv
// Synchronizes the 10 Hz slow clock into a single-cycle tick and debounces
// the button/coin inputs on those ticks, producing levels and edge pulses.
module vend_input_conditioner #(
  parameter int NUM_BTN   = 4,
  parameter int DEB_TICKS = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  vend_input_conditioner_if.slave bus
);
  localparam int CW = $clog2(DEB_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_TICKS - 1);

  logic               s1, s2, s3;
  logic               tick_q;
  logic [NUM_BTN-1:0] btn_meta;
  logic [NUM_BTN-1:0] btn_sync;
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] press_q;
  logic [NUM_BTN-1:0] rel_q;
  logic [CW-1:0]      cnt [NUM_BTN];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      tick_q   <= 1'b0;
      btn_meta <= '0;
      btn_sync <= '0;
      level_q  <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
    end else begin
      s1       <= bus.slow_CLK;
      s2       <= s1;
      s3       <= s2;
      tick_q   <= s2 & ~s3;
      btn_meta <= bus.btn_in;
      btn_sync <= btn_meta;
      press_q  <= '0;
      rel_q    <= '0;
      if (tick_q) begin
        // A single disagreeing sample restarts the count for that bit only.
        for (int i = 0; i < NUM_BTN; i++) begin
          if (btn_sync[i] == level_q[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == LAST) begin
            level_q[i] <= btn_sync[i];
            cnt[i]     <= '0;
            if (btn_sync[i]) press_q[i] <= 1'b1;
            else             rel_q[i]   <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign bus.tick        = tick_q;
  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = rel_q;
endmodule

// File: tb/tb_vend_input_conditioner.sv
// Directed bench for vend_input_conditioner: expected ticks and pulses are queued
// as stimulus is applied and checked by a negedge monitor when the DUT emits them.
module tb_vend_input_conditioner;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lvl;
  } ev_t;

  ev_t evq[$];
  int  tickq[$];

  vend_input_conditioner_if #(.NUM_BTN(4)) bus ();

  vend_input_conditioner #(.NUM_BTN(4), .DEB_TICKS(3)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every tick and every pulse must match a queued expectation.
  always @(negedge CLK) begin
    if (bus.tick === 1'b1) begin
      if (tickq.size() == 0) check("tick_unexpected", cyc, 0);
      else                   check("tick_cycle", cyc, tickq.pop_front());
    end
    if ((bus.btn_press | bus.btn_release) !== 4'b0000) begin
      if (evq.size() == 0) begin
        check("pulse_unexpected", {24'd0, bus.btn_press, bus.btn_release}, 0);
      end else begin
        ev_t e;
        e = evq.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("press", {28'd0, bus.btn_press}, {28'd0, e.press});
        check("release", {28'd0, bus.btn_release}, {28'd0, e.rel});
        check("level_at_pulse", {28'd0, bus.btn_level}, {28'd0, e.lvl});
      end
    end
  end

  // One slow_CLK period. Inputs are stable around the rising edge; bits in
  // chat toggle an even number of times while slow_CLK is low.
  task automatic do_tick(input logic [3:0] ep, input logic [3:0] er,
                         input logic [3:0] el, input logic [3:0] chat);
    int k;
    @(negedge CLK);
    @(negedge CLK);
    bus.slow_CLK = 1'b1;
    k = cyc + 1;
    tickq.push_back(k + 2);
    if ((ep | er) != 4'b0000) evq.push_back('{k + 3, ep, er, el});
    repeat (5) @(negedge CLK);
    bus.slow_CLK = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      bus.btn_in = bus.btn_in ^ chat;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tick"}, {31'd0, bus.tick}, 0);
    check({tag, "_level"}, {28'd0, bus.btn_level}, 0);
    check({tag, "_press"}, {28'd0, bus.btn_press}, 0);
    check({tag, "_release"}, {28'd0, bus.btn_release}, 0);
  endtask

  initial begin
    bus.slow_CLK = 1'b0;
    bus.btn_in   = 4'b0000;
    repeat (3) @(negedge CLK);
    check_outputs_zero("reset");
    RST = 1'b0;

    // idle ticks
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("idle_level", {28'd0, bus.btn_level}, 0);

    // bit0 steady high: press after third tick
    bus.btn_in = 4'b0001;
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("b0_level_pre", {28'd0, bus.btn_level}, 0);
    do_tick(4'b0001, 4'b0000, 4'b0001, 4'b0000);
    check("b0_level", {28'd0, bus.btn_level}, 32'h1);

    // bit1: high 2, low 1, high 3
    bus.btn_in = 4'b0011;
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    bus.btn_in = 4'b0001;
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    bus.btn_in = 4'b0011;
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("b1_level_pre", {28'd0, bus.btn_level}, 32'h1);
    do_tick(4'b0010, 4'b0000, 4'b0011, 4'b0000);

    // bit2 chatters between ticks, high at every tick sample
    bus.btn_in = 4'b0111;
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0100);
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0100);
    do_tick(4'b0100, 4'b0000, 4'b0111, 4'b0100);
    check("b2_level", {28'd0, bus.btn_level}, 32'h7);

    // release several bits at once
    bus.btn_in = 4'b0000;
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    do_tick(4'b0000, 4'b0111, 4'b0000, 4'b0000);

    // bits 0 and 3 together
    bus.btn_in = 4'b1001;
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    do_tick(4'b1001, 4'b0000, 4'b1001, 4'b0000);
    bus.btn_in = 4'b0000;
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    do_tick(4'b0000, 4'b1001, 4'b0000, 4'b0000);

    // reset mid-count
    bus.btn_in = 4'b0010;
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    do_tick(4'b0010, 4'b0000, 4'b0010, 4'b0000);
    bus.btn_in = 4'b0011;
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_outputs_zero("mid_reset");
    RST = 1'b0;
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    do_tick(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("post_reset_level_pre", {28'd0, bus.btn_level}, 0);
    do_tick(4'b0011, 4'b0000, 4'b0011, 4'b0000);
    check("post_reset_level", {28'd0, bus.btn_level}, 32'h3);

    repeat (20) @(negedge CLK);
    check("tick_queue_drained", tickq.size(), 0);
    check("event_queue_drained", evq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vend_input_conditioner.md
# vend_input_conditioner

Front-end conditioning stage for the vending machine that consumes the 10 Hz `slow_CLK` produced by the clock divider and the raw push-button/coin-switch inputs. It runs on the 100 MHz system clock and converts `slow_CLK` into a one-cycle `tick` enable. It uses those ticks to debounce up to `NUM_BTN` asynchronous inputs and emits clean levels plus one-cycle press/release pulses for the vending FSM. All outputs are synchronous to `CLK`; nothing downstream is clocked by `slow_CLK` directly.

## Interface
- `NUM_BTN`, default 4: number of button/coin inputs, range 1..16.
- `DEB_TICKS`, default 3: consecutive tick samples an input must hold a new value before the debounced level changes, range 1..15.
- `CLK` input 1: 100 MHz system clock, rising edge.
- `RST` input 1: reset, asynchronous, active-high.
- `slow_CLK` input 1: 10 Hz square wave from the clock divider; treated as asynchronous.
- `btn_in` input `NUM_BTN`: raw, bouncing, asynchronous inputs, active-high.
- `tick` output 1: one-`CLK`-cycle pulse per `slow_CLK` rising edge.
- `btn_level` output `NUM_BTN`: debounced input levels.
- `btn_press` output `NUM_BTN`: one-cycle pulse per bit on a debounced 0->1 transition.
- `btn_release` output `NUM_BTN`: one-cycle pulse per bit on a debounced 1->0 transition.

## Operation
- `slow_CLK` path:
  - Two-flop synchronizer (s1, s2), then a history flop s3.
  - Registered `tick` <= s2 & ~s3.
- `btn_in` path: each bit passes through its own two-flop synchronizer to produce `btn_sync[i]`.
- Per-bit debounce uses an independent counter `cnt[i]` of width $clog2(DEB_TICKS+1). Evaluation happens only in cycles where `tick`=1:
  - If `btn_sync[i]` == `btn_level[i]`: `cnt[i]` <= 0.
  - Else if `cnt[i]` == `DEB_TICKS`-1:
    - `btn_level[i]` <= `btn_sync[i]` and `cnt[i]` <= 0.
    - Assert `btn_press[i]` (new level 1) or `btn_release[i]` (new level 0) for the next cycle.
  - Else: `cnt[i]` <= `cnt[i]`+1.
- In cycles where `tick`=0, counters and levels hold, and `btn_press`/`btn_release` are 0.
- With `DEB_TICKS`=1, the level follows the synchronized sample at every tick.
- Bits are fully independent. Several `btn_press`/`btn_release` bits may assert in the same cycle.
- A single differing sample followed by a matching one clears the counter, so no level change occurs.

## Timing
- Reset values: all flops are 0. `tick`, `btn_level`, `btn_press`, `btn_release` and all counters are 0.
- `tick` latency: `slow_CLK` rises with setup met before `CLK` edge k; `tick` is high for exactly the one cycle after edge k+2. Exactly one tick per `slow_CLK` period, i.e. every 10,000,000 cycles at nominal rates.
- Reset release with `slow_CLK` already high yields one tick. In the system, the divider shares `RST` and holds `slow_CLK` at 0, so this does not occur in practice.
- Debounce latency: the input change must be stable in `btn_sync` at `DEB_TICKS` consecutive ticks.
  - `btn_level` and the press/release pulse update on the edge that ends the last qualifying tick cycle.
  - Worst case `DEB_TICKS`+1 `slow_CLK` periods plus 4 `CLK` cycles from the input change.
- `btn_press`/`btn_release` are high for exactly 1 `CLK` cycle and never together for the same bit.
- `RST` asserted mid-operation clears all state immediately, including partially accumulated counts and pulses in flight. There is no pulse on deassertion.

## Test plan
- Reset, then toggle `slow_CLK` at 10 Hz (scaled period allowed) -> `tick` is exactly 1 cycle wide, 3 edges after each `slow_CLK` rise, none on falls; all other outputs 0.
- `btn_in[0]` goes 1 and holds, `DEB_TICKS`=3 -> `btn_level[0]` rises and `btn_press[0]` pulses once, in the cycle after the 3rd tick sampling 1; other bits stay 0.
- `btn_in[1]` high for 2 ticks, low for 1, then high for 3 -> a single `btn_press[1]`, only after the final 3 consecutive samples.
- `btn_in[2]` chatters at `CLK` rate between ticks but is stable at the tick samples -> the level follows the tick samples only, with no extra pulses.
- `btn_in[0]` and `btn_in[3]` rise in the same cycle -> `btn_press` = 4'b1001 in a single cycle; a later simultaneous fall gives `btn_release` = 4'b1001.
- `RST` pulsed after 2 of 3 qualifying ticks -> all outputs 0; a fresh 3 ticks are required before `btn_press` asserts.
